// File: rtl/prio_flop_pipe.sv
// prio_flop_pipe: multi-writer register pipeline with a valid/ready handshake
// at both ends. Concurrent writes resolve so that the highest-index enabled
// port wins. Each stage tracks its own valid bit. A full pipe refuses writes,
// and every refused write is counted in a saturating drop counter. A
// synchronous clear empties the pipe and zeroes the counter.
module prio_flop_pipe #(
  parameter int SIZE   = 1,
  parameter int DEPTH  = 2,
  parameter int NPORTS = 3,
  parameter int CNTW   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sclr,
  input  logic [NPORTS-1:0]        wr_en,
  input  logic [NPORTS*SIZE-1:0]   wr_data,
  output logic                     in_ready,
  output logic [SIZE-1:0]          q,
  output logic                     q_valid,
  input  logic                     q_ready,
  output logic [CNTW-1:0]          drop_cnt
);

  // Increment that holds at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    if (&c) return c;
    return c + 1'b1;
  endfunction

  // Stage state.
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [SIZE-1:0]  d_q [DEPTH];
  logic [SIZE-1:0]  d_d [DEPTH];
  logic [CNTW-1:0]  cnt_q;
  logic [CNTW-1:0]  cnt_d;

  // Handshake and write-resolution signals.
  logic [DEPTH-1:0] adv;
  logic             any_wr;
  logic [SIZE-1:0]  sel_data;
  logic             load0;

  // Priority write select: later (higher-index) ports overwrite earlier ones,
  // so the highest enabled port ends up in sel_data.
  always_comb begin
    sel_data = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (wr_en[p]) sel_data = wr_data[p*SIZE +: SIZE];
    end
    any_wr = |wr_en;
  end

  // Advance chain is built from the output back to the input. It depends
  // only on valid bits and q_ready and never on the write request, so
  // in_ready has no path from wr_en or wr_data.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = v_q[DEPTH-1] & q_ready;
    for (int i = DEPTH-2; i >= 0; i--) begin
      adv[i] = v_q[i] & (~v_q[i+1] | adv[i+1]);
    end
    in_ready = ~v_q[0] | adv[0];
    load0    = any_wr & in_ready;
  end

  // Next-state for stages and drop counter. Data moves only on a load, so a
  // stage that drains keeps its stale contents. sclr overrides everything.
  always_comb begin
    v_d   = v_q;
    cnt_d = cnt_q;
    for (int i = 0; i < DEPTH; i++) d_d[i] = d_q[i];

    if (load0) begin
      v_d[0] = 1'b1;
      d_d[0] = sel_data;
    end else if (adv[0]) begin
      v_d[0] = 1'b0;
    end

    for (int i = 1; i < DEPTH; i++) begin
      if (adv[i-1]) begin
        v_d[i] = 1'b1;
        d_d[i] = d_q[i-1];
      end else if (adv[i]) begin
        v_d[i] = 1'b0;
      end
    end

    if (any_wr && !in_ready) cnt_d = sat_inc(cnt_q);

    if (sclr) begin
      v_d   = '0;
      cnt_d = '0;
      for (int i = 0; i < DEPTH; i++) d_d[i] = '0;
    end
  end

  // State registers. Reset clears data as well as control, so q reads zero
  // both during reset and right after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
    end
  end

  assign q        = d_q[DEPTH-1];
  assign q_valid  = v_q[DEPTH-1];
  assign drop_cnt = cnt_q;

endmodule
